// File: rtl/nn_mem_model.sv
// ---------------------------------------------------------------------------
// nn_mem_model
//
// Memory-side responder for the NN data memory interface. It is the model
// side of memIntf: one clocked write port, eight independent read ports and
// DEPTH words of 24-bit data. After reset the array is swept to zero. Only
// once the sweep has finished does the model accept writes and return stored
// data. Protocol anomalies are counted in saturating status counters.
//
// Ports (the memIntf members are flattened, with an m_ prefix):
//   clk        : system clock (also the memIntf clock)
//   reset      : synchronous, active-high reset
//   m_aw       : write address
//   m_write    : write strobe
//   m_wd       : write data
//   m_a        : eight read addresses, one per read port
//   m_d        : eight read results, READ_LATENCY cycles after m_a is sampled
//   init_done  : high once the zero-fill sweep has completed
//   wr_count   : writes accepted since reset
//   oob_count  : out-of-range write plus read attempts since reset (RUN only)
//   drop_count : writes dropped because the sweep was still running
// ---------------------------------------------------------------------------
module nn_mem_model #(
   parameter int DEPTH        = 65536,
   parameter int READ_LATENCY = 1,
   parameter int WRITE_FIRST  = 1,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [15:0]           m_aw,
   input  logic                  m_write,
   input  logic [23:0]           m_wd,
   input  logic [7:0][15:0]      m_a,
   output logic [7:0][23:0]      m_d,
   output logic                  init_done,
   output logic [CNT_W-1:0]      wr_count,
   output logic [CNT_W-1:0]      oob_count,
   output logic [CNT_W-1:0]      drop_count
);

   localparam int              DATA_W  = 24;
   localparam int              NPORT   = 8;
   localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [16:0]     DEPTH_L = 17'(DEPTH);
   localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);

   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

   state_t                    state, state_nx;
   logic [AW-1:0]             ptr, ptr_nx;

   logic [DATA_W-1:0]         mem [0:DEPTH-1];

   logic                      run;
   logic                      aw_rng;
   logic [AW-1:0]             aw_idx;
   logic                      wr_ok;
   logic                      wr_oob;
   logic                      wr_drop;
   logic [NPORT-1:0]          rd_oob;
   logic [3:0]                rd_oob_n;
   logic [3:0]                oob_inc;
   logic [NPORT-1:0][DATA_W-1:0] rdata_nx;
   logic [NPORT-1:0][DATA_W-1:0] rdata_p0;

   // Saturating add for the status counters; an increment of at most 9
   // always fits in the extra headroom bits.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                input logic [3:0]       inc);
      logic [CNT_W+4:0] s;
      s = {5'd0, c} + {{(CNT_W+1){1'b0}}, inc};
      if (s > {5'd0, {CNT_W{1'b1}}})
         return {CNT_W{1'b1}};
      else
         return s[CNT_W-1:0];
   endfunction

   // Result of one read port before it is registered. An out-of-range read
   // and any read during the sweep return zero. With WRITE_FIRST the write
   // data is forwarded when the read hits the address being written.
   function automatic logic [DATA_W-1:0] rd_sel(input logic              is_run,
                                                input logic              in_rng,
                                                input logic              fwd,
                                                input logic [DATA_W-1:0] stored,
                                                input logic [DATA_W-1:0] wdata);
      if (!is_run || !in_rng)
         return '0;
      else if (fwd)
         return wdata;
      else
         return stored;
   endfunction

   // ---------------- sweep / run control ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      case (state)
         CLEAR: begin
            if (ptr == LAST) begin
               state_nx = RUN;
               ptr_nx   = '0;
            end else begin
               ptr_nx   = ptr + AW'(1);
            end
         end
         RUN: begin
            state_nx = RUN;
         end
         default: begin
            state_nx = CLEAR;
            ptr_nx   = '0;
         end
      endcase
   end

   assign run       = (state == RUN);
   assign init_done = run;

   // The range check uses the full 16-bit address. Only after it passes are
   // the low index bits used to address the array.
   assign aw_rng  = ({1'b0, m_aw} < DEPTH_L);
   assign aw_idx  = m_aw[AW-1:0];
   assign wr_ok   = run &  m_write &  aw_rng;
   assign wr_oob  = run &  m_write & ~aw_rng;
   assign wr_drop = ~run & m_write;

   // ---------------- storage ----------------
   // The array is not reset. The sweep zeroes it one word per cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == CLEAR)
            mem[ptr] <= '0;
         else if (wr_ok)
            mem[aw_idx] <= m_wd;
      end
   end

   // ---------------- read stage p0 (address sampled) ----------------
   always_comb begin
      rd_oob   = '0;
      rd_oob_n = '0;
      rdata_nx = '0;
      for (int i = 0; i < NPORT; i++) begin
         logic in_rng;
         logic fwd;
         in_rng = ({1'b0, m_a[i]} < DEPTH_L);
         fwd    = (WRITE_FIRST != 0) && wr_ok && (m_a[i] == m_aw);
         rd_oob[i]   = run & ~in_rng;
         rd_oob_n    = rd_oob_n + 4'(rd_oob[i]);
         rdata_nx[i] = rd_sel(run, in_rng, fwd, mem[m_a[i][AW-1:0]], m_wd);
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         rdata_p0 <= '0;
      else
         rdata_p0 <= rdata_nx;
   end

   // ---------------- optional read stage p1 ----------------
   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic [NPORT-1:0][DATA_W-1:0] rdata_p1;
         always_ff @(posedge clk) begin
            if (reset)
               rdata_p1 <= '0;
            else
               rdata_p1 <= rdata_p0;
         end
         assign m_d = rdata_p1;
      end else begin : g_lat1
         assign m_d = rdata_p0;
      end
   endgenerate

   // ---------------- status counters ----------------
   assign oob_inc = 4'(wr_oob) + rd_oob_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_count   <= '0;
         oob_count  <= '0;
         drop_count <= '0;
      end else begin
         wr_count   <= sat_add(wr_count,   4'(wr_ok));
         oob_count  <= sat_add(oob_count,  oob_inc);
         drop_count <= sat_add(drop_count, 4'(wr_drop));
      end
   end

endmodule

// File: tb/tb_nn_mem_model.sv
// Two instances share one stimulus stream:
//   u_a : DEPTH=16, READ_LATENCY=1, WRITE_FIRST=1, CNT_W=16
//   u_b : DEPTH=16, READ_LATENCY=2, WRITE_FIRST=0, CNT_W=2
// Read expectations are queued per instance when a read is issued. A monitor
// on the falling edge pops them when that instance's data is due.
module tb_nn_mem_model;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [15:0]       aw = '0;
   logic              write = 1'b0;
   logic [23:0]       wd = '0;
   logic [7:0][15:0]  a = '0;

   logic [7:0][23:0]  da, db;
   logic              init_a, init_b;
   logic [15:0]       wr_a, oob_a, drop_a;
   logic [1:0]        wr_b, oob_b, drop_b;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int          due;
      int          port;
      logic [23:0] exp;
   } rd_t;

   rd_t qa[$];
   rd_t qb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   nn_mem_model #(.DEPTH(16), .READ_LATENCY(1), .WRITE_FIRST(1), .CNT_W(16)) u_a (
      .clk(clk), .reset(reset), .m_aw(aw), .m_write(write), .m_wd(wd),
      .m_a(a), .m_d(da), .init_done(init_a),
      .wr_count(wr_a), .oob_count(oob_a), .drop_count(drop_a));

   nn_mem_model #(.DEPTH(16), .READ_LATENCY(2), .WRITE_FIRST(0), .CNT_W(2)) u_b (
      .clk(clk), .reset(reset), .m_aw(aw), .m_write(write), .m_wd(wd),
      .m_a(a), .m_d(db), .init_done(init_b),
      .wr_count(wr_b), .oob_count(oob_b), .drop_count(drop_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queue an expected read result for a port that is being driven this
   // cycle; ea is the u_a answer, eb the u_b answer.
   task automatic exp_rd(input int port, input logic [23:0] ea, input logic [23:0] eb);
      qa.push_back('{cyc + 1, port, ea});
      qb.push_back('{cyc + 2, port, eb});
   endtask

   task automatic do_write(input logic [15:0] addr, input logic [23:0] data);
      aw = addr; wd = data; write = 1'b1;
      tick();
      write = 1'b0;
   endtask

   task automatic drain();
      a = '0;
      repeat (3) tick();
   endtask

   task automatic wait_sweep(input string name);
      int n;
      n = 0;
      while (!init_a && n < 40) begin
         tick();
         n++;
      end
      chk(name, 32'(n), 32'd16);
      chk({name, "_b"}, 32'(init_b), 32'd1);
   endtask

   always @(negedge clk) begin
      rd_t e;
      while (qa.size() > 0 && qa[0].due <= cyc) begin
         e = qa.pop_front();
         checks++;
         if (da[e.port] !== e.exp || e.due != cyc) begin
            failures++;
            $display("FAIL rd_a port%0d cyc%0d: got %06h want %06h", e.port, cyc, da[e.port], e.exp);
         end
      end
      while (qb.size() > 0 && qb[0].due <= cyc) begin
         e = qb.pop_front();
         checks++;
         if (db[e.port] !== e.exp || e.due != cyc) begin
            failures++;
            $display("FAIL rd_b port%0d cyc%0d: got %06h want %06h", e.port, cyc, db[e.port], e.exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      // Reset state
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_init_a", 32'(init_a), 32'd0);
      chk("rst_init_b", 32'(init_b), 32'd0);
      chk("rst_wr_a",   32'(wr_a),   32'd0);
      chk("rst_oob_a",  32'(oob_a),  32'd0);
      chk("rst_drop_b", 32'(drop_b), 32'd0);
      for (int i = 0; i < 8; i++) begin
         chk("rst_d_a", 32'(da[i]), 32'd0);
         chk("rst_d_b", 32'(db[i]), 32'd0);
      end

      // Write during the sweep is dropped; a read during the sweep returns 0
      aw = 16'd3; wd = 24'hABCDEF; write = 1'b1;
      a[1] = 16'd3;
      exp_rd(1, 24'h0, 24'h0);
      tick();
      write = 1'b0;
      a = '0;
      n = 1;
      while (!init_a && n < 40) begin
         tick();
         n++;
      end
      chk("sweep_len", 32'(n), 32'd16);
      chk("sweep_b",   32'(init_b), 32'd1);
      chk("drop_a", 32'(drop_a), 32'd1);
      chk("drop_b", 32'(drop_b), 32'd1);
      chk("wr_after_drop_a", 32'(wr_a), 32'd0);

      a[0] = 16'd3;
      exp_rd(0, 24'h0, 24'h0);
      tick();
      a = '0;

      // Write then read on all eight ports
      do_write(16'd5, 24'h123456);
      for (int i = 0; i < 8; i++) begin
         a[i] = 16'd5;
         exp_rd(i, 24'h123456, 24'h123456);
      end
      tick();
      a = '0;
      chk("wr_cnt1_a", 32'(wr_a), 32'd1);
      chk("wr_cnt1_b", 32'(wr_b), 32'd1);

      // Read during write: u_a forwards the new data, u_b returns the old
      do_write(16'd7, 24'h000011);
      do_write(16'd6, 24'h000066);
      aw = 16'd7; wd = 24'h0000FF; write = 1'b1;
      a[2] = 16'd7;
      a[3] = 16'd6;
      exp_rd(2, 24'h0000FF, 24'h000011);
      exp_rd(3, 24'h000066, 24'h000066);
      tick();
      write = 1'b0;
      a = '0;
      a[2] = 16'd7;
      exp_rd(2, 24'h0000FF, 24'h0000FF);
      tick();
      a = '0;
      chk("wr_cnt4_a",   32'(wr_a), 32'd4);
      chk("wr_sat_b",    32'(wr_b), 32'd3);

      // Back-to-back reads through the pipeline
      do_write(16'd1, 24'h00000A);
      do_write(16'd2, 24'h00000B);
      do_write(16'd3, 24'h00000C);
      a[0] = 16'd1; exp_rd(0, 24'h00000A, 24'h00000A); tick();
      a[0] = 16'd2; exp_rd(0, 24'h00000B, 24'h00000B); tick();
      a[0] = 16'd3; exp_rd(0, 24'h00000C, 24'h00000C); tick();
      a = '0;
      chk("wr_cnt7_a", 32'(wr_a), 32'd7);

      // Out-of-range write and reads
      aw = 16'd20; wd = 24'h5A5A5A; write = 1'b1;
      a[0] = 16'd16;
      a[1] = 16'd17;
      exp_rd(0, 24'h0, 24'h0);
      exp_rd(1, 24'h0, 24'h0);
      tick();
      write = 1'b0;
      a = '0;
      chk("oob3_a", 32'(oob_a), 32'd3);
      chk("oob3_b", 32'(oob_b), 32'd3);
      chk("oob_nostore_wr_a", 32'(wr_a), 32'd7);
      a[0] = 16'd4;
      exp_rd(0, 24'h0, 24'h0);
      tick();
      a = '0;
      do_write(16'h8000, 24'h111111);
      do_write(16'hFFFF, 24'h222222);
      chk("oob5_a",   32'(oob_a), 32'd5);
      chk("oob_sat_b", 32'(oob_b), 32'd3);
      for (int i = 0; i < 8; i++) begin
         a[i] = 16'hFFFF;
         exp_rd(i, 24'h0, 24'h0);
      end
      tick();
      a = '0;
      chk("oob13_a",  32'(oob_a), 32'd13);
      chk("oob_sat2_b", 32'(oob_b), 32'd3);

      // Reset in the middle of the sweep
      do_write(16'd12, 24'h00CC12);
      a[0] = 16'd12;
      exp_rd(0, 24'h00CC12, 24'h00CC12);
      tick();
      drain();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (9) tick();
      chk("mid_init_a", 32'(init_a), 32'd0);
      reset = 1'b1;
      tick();
      chk("mid_rst_init_a", 32'(init_a), 32'd0);
      chk("mid_rst_wr_a",   32'(wr_a),   32'd0);
      chk("mid_rst_oob_a",  32'(oob_a),  32'd0);
      chk("mid_rst_drop_a", 32'(drop_a), 32'd0);
      reset = 1'b0;
      wait_sweep("resweep_len");
      a[0] = 16'd12;
      exp_rd(0, 24'h0, 24'h0);
      tick();
      drain();
      chk("post_wr_a",   32'(wr_a),   32'd0);
      chk("post_oob_a",  32'(oob_a),  32'd0);
      chk("post_drop_a", 32'(drop_a), 32'd0);
      chk("post_wr_b",   32'(wr_b),   32'd0);
      chk("post_oob_b",  32'(oob_b),  32'd0);

      chk("qa_empty", 32'(qa.size()), 32'd0);
      chk("qb_empty", 32'(qb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
